// File: rtl/fix_pkg.sv
// Shared constants and the framer state encoding for the FIX receive path.
package fix_pkg;

  localparam logic [7:0] SOH      = 8'h01;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_8  = 8'h38;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_1  = 8'h31;
  localparam logic [7:0] ASCII_9  = 8'h39;

  // Defaults shared with fix_decoder; the two blocks must agree on these.
  localparam int FIX_PAYLOAD_LEN_DEFAULT = 220;
  localparam int FIX_HEADER_LEN_DEFAULT  = 42;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    SAW8  = 3'd1,
    BODY  = 3'd2,
    TRL0  = 3'd3,
    TRL1  = 3'd4,
    TRL2  = 3'd5,
    TRLS  = 3'd6,
    CHECK = 3'd7
  } framer_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/fix_trailer_parser.sv
// Parses the "ddd<SOH>" CheckSum trailer: accumulates the decimal value of
// the three digits and flags any byte that does not fit the trailer shape.
module fix_trailer_parser
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,       // hold value at zero outside the trailer
  input  logic       byte_en,     // a trailer byte is accepted this cycle
  input  logic       expect_soh,  // 1: final SOH expected, 0: digit expected
  input  logic [7:0] rx_byte,
  output logic [9:0] value,
  output logic       format_err   // combinational, qualified by byte_en
);

  logic       digit_ok;
  logic [9:0] value_next;

  // Classify the current byte and form value*10 + digit.
  always_comb begin
    digit_ok   = is_digit(rx_byte);
    value_next = (value << 3) + (value << 1) + {6'd0, rx_byte[3:0]};
    format_err = 1'b0;
    if (byte_en) begin
      if (expect_soh) format_err = (rx_byte != SOH);
      else            format_err = !digit_ok;
    end
  end

  // Decimal accumulator; three digits never exceed 999 so 10 bits suffice.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (byte_en && !expect_soh && digit_ok) begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/fix_rx_framer.sv
// Finds FIX message boundaries in the raw receive byte stream, checks the
// CheckSum trailer and hands good frames to fix_decoder as a flat vector.
//
// Handshake: a byte moves on every rising edge where rx_valid && rx_ready.
// rx_valid may be held high indefinitely; while rx_ready is low the source
// keeps rx_data stable and nothing is consumed. rx_ready is low only in
// CHECK, so the byte waiting on the bus is taken the cycle after.
module fix_rx_framer
  import fix_pkg::*;
#(
  parameter int FIX_PAYLOAD_LEN = FIX_PAYLOAD_LEN_DEFAULT,
  parameter int FIX_HEADER_LEN  = FIX_HEADER_LEN_DEFAULT,
  localparam int FRAME_BYTES    = FIX_PAYLOAD_LEN + FIX_HEADER_LEN,
  localparam int LEN_W          = $clog2(FRAME_BYTES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [FRAME_BYTES*8-1:0] frame_data,
  output logic [LEN_W-1:0]         frame_len,
  output logic                     frame_valid,
  output logic                     checksum_error,
  output logic                     format_error,
  output logic                     overflow_error,
  output logic                     busy,
  output framer_state_e            state_dbg
);

  localparam int IDX_W = $clog2(FRAME_BYTES * 8);

  framer_state_e state_q, state_d;

  logic [FRAME_BYTES*8-1:0] frame_q;
  logic [LEN_W-1:0]         len_q;
  logic [7:0]               sum_q;
  logic [7:0]               soh_sum_q;
  logic [7:0]               checksum_q;
  logic [2:0][7:0]          recent_q;   // [0] is the most recent body byte
  logic                     fv_q, ce_q, fe_q, oe_q;

  logic             accept;
  logic [7:0]       sum_next;
  logic             tag1, tag2, tag_hit;
  logic             body_ovf;
  logic [IDX_W-1:0] wr_msb;
  logic             in_trailer;
  logic             trl_byte_en;
  logic [9:0]       trl_value;
  logic             trl_fmt_err;

  // Handshake, tag detection and write position for the current byte.
  always_comb begin
    rx_ready    = (state_q != CHECK);
    accept      = rx_valid && rx_ready;
    sum_next    = sum_q + rx_data;
    tag1        = (recent_q[0] == SOH) && (rx_data == ASCII_1);
    tag2        = (recent_q[1] == SOH) && (recent_q[0] == ASCII_1) &&
                  (rx_data == ASCII_0);
    tag_hit     = (recent_q[2] == SOH) && (recent_q[1] == ASCII_1) &&
                  (recent_q[0] == ASCII_0) && (rx_data == ASCII_EQ);
    // A full frame may still take the "10=" tag bytes; anything else overflows.
    body_ovf    = (len_q >= LEN_W'(FRAME_BYTES)) && !(tag1 || tag2 || tag_hit);
    wr_msb      = IDX_W'(FRAME_BYTES*8 - 1) - IDX_W'({len_q, 3'b000});
    in_trailer  = (state_q == TRL0) || (state_q == TRL1) ||
                  (state_q == TRL2) || (state_q == TRLS);
    trl_byte_en = accept && in_trailer;
  end

  fix_trailer_parser u_trailer (
    .clk        (clk),
    .rst        (rst),
    .clear      (!in_trailer),
    .byte_en    (trl_byte_en),
    .expect_soh (state_q == TRLS),
    .rx_byte    (rx_data),
    .value      (trl_value),
    .format_err (trl_fmt_err)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: if (accept && rx_data == ASCII_8) state_d = SAW8;
      SAW8: if (accept) begin
        if (rx_data == ASCII_EQ)     state_d = BODY;
        else if (rx_data == ASCII_8) state_d = SAW8;
        else                         state_d = SYNC;
      end
      BODY: if (accept) begin
        if (body_ovf)     state_d = SYNC;
        else if (tag_hit) state_d = TRL0;
      end
      TRL0: if (accept) state_d = trl_fmt_err ? SYNC : TRL1;
      TRL1: if (accept) state_d = trl_fmt_err ? SYNC : TRL2;
      TRL2: if (accept) state_d = trl_fmt_err ? SYNC : TRLS;
      TRLS: if (accept) state_d = trl_fmt_err ? SYNC : CHECK;
      CHECK: state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // Frame assembly, running sums and the single-cycle result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q    <= '0;
      len_q      <= '0;
      sum_q      <= '0;
      soh_sum_q  <= '0;
      checksum_q <= '0;
      recent_q   <= '0;
      fv_q       <= 1'b0;
      ce_q       <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      ce_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
      case (state_q)
        SAW8: if (accept && rx_data == ASCII_EQ) begin
          frame_q   <= {ASCII_8, ASCII_EQ, {(FRAME_BYTES-2)*8{1'b0}}};
          len_q     <= LEN_W'(2);
          sum_q     <= ASCII_8 + ASCII_EQ;
          soh_sum_q <= '0;
          recent_q  <= '0;
        end
        BODY: if (accept) begin
          if (body_ovf) begin
            oe_q <= 1'b1;
          end else if (tag_hit) begin
            // Drop the "1" and "0" already stored; "=" is never stored.
            len_q      <= len_q - LEN_W'(2);
            checksum_q <= soh_sum_q;
            if ((len_q - LEN_W'(1)) < LEN_W'(FRAME_BYTES))
              frame_q[wr_msb + IDX_W'(8) -: 8] <= 8'h00;
            if ((len_q - LEN_W'(2)) < LEN_W'(FRAME_BYTES))
              frame_q[wr_msb + IDX_W'(16) -: 8] <= 8'h00;
          end else begin
            // Tag bytes past capacity are only tracked, not stored.
            if (len_q < LEN_W'(FRAME_BYTES))
              frame_q[wr_msb -: 8] <= rx_data;
            len_q    <= len_q + LEN_W'(1);
            sum_q    <= sum_next;
            recent_q <= {recent_q[1:0], rx_data};
            if (rx_data == SOH) soh_sum_q <= sum_next;
          end
        end
        TRL0, TRL1, TRL2, TRLS: if (trl_byte_en && trl_fmt_err) fe_q <= 1'b1;
        CHECK: begin
          if (trl_value == {2'b00, checksum_q}) fv_q <= 1'b1;
          else                                  ce_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign frame_data     = frame_q;
  assign frame_len      = len_q;
  assign frame_valid    = fv_q;
  assign checksum_error = ce_q;
  assign format_error   = fe_q;
  assign overflow_error = oe_q;
  assign busy           = (state_q != SYNC);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fix_rx_framer.sv
// Directed bench for fix_rx_framer. Inputs change on the falling edge;
// a monitor samples the result pulses 2 ns after each rising edge.
module tb_fix_rx_framer;
  import fix_pkg::*;

  localparam int FB = 262;
  localparam int LW = $clog2(FB + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_ready;
  logic [FB*8-1:0] frame_data;
  logic [LW-1:0]   frame_len;
  logic            frame_valid;
  logic            checksum_error;
  logic            format_error;
  logic            overflow_error;
  logic            busy;
  framer_state_e   state_dbg;

  int checks = 0;
  int errors = 0;

  int            fv_cnt, ce_cnt, fe_cnt, oe_cnt, multi_cnt;
  logic [LW-1:0] last_len;
  logic [31:0]   last_top;

  fix_rx_framer dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .frame_data     (frame_data),
    .frame_len      (frame_len),
    .frame_valid    (frame_valid),
    .checksum_error (checksum_error),
    .format_error   (format_error),
    .overflow_error (overflow_error),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // Pulse monitor: counts each result pulse and any cycle with two at once.
  always begin
    @(posedge clk);
    #2;
    if (frame_valid) begin
      fv_cnt++;
      last_len = frame_len;
      last_top = frame_data[FB*8-1 -: 32];
    end
    if (checksum_error) ce_cnt++;
    if (format_error)   fe_cnt++;
    if (overflow_error) oe_cnt++;
    if ((int'(frame_valid) + int'(checksum_error) + int'(format_error) +
         int'(overflow_error)) > 1) multi_cnt++;
  end

  task automatic clear_counts();
    fv_cnt = 0; ce_cnt = 0; fe_cnt = 0; oe_cnt = 0; multi_cnt = 0;
    last_len = '0; last_top = '0;
  endtask

  // Present one byte and return at the falling edge after it was taken.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    rx_data  = b;
    rx_valid = 1'b1;
    guard = 0;
    while (!rx_ready && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 16) begin
      checks++;
      errors++;
      $display("FAIL send_byte: rx_ready stuck low, byte %0h not accepted", b);
    end
    @(negedge clk);
  endtask

  // '|' stands for SOH.
  task automatic send_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      send_byte((c == 8'h7C) ? SOH : c);
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_counts(input string name, input int fv, input int ce,
                              input int fe, input int oe);
    checks++;
    if (fv_cnt !== fv || ce_cnt !== ce || fe_cnt !== fe || oe_cnt !== oe ||
        multi_cnt !== 0) begin
      errors++;
      $display("FAIL %s counts: got fv=%0d ce=%0d fe=%0d oe=%0d multi=%0d expected fv=%0d ce=%0d fe=%0d oe=%0d multi=0",
               name, fv_cnt, ce_cnt, fe_cnt, oe_cnt, multi_cnt, fv, ce, fe, oe);
    end
  endtask

  task automatic test_reset();
    logic [FB*8-1:0] zero_frame;
    zero_frame = '0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (frame_data !== zero_frame || frame_len !== '0) begin
      errors++;
      $display("FAIL reset_frame: got len=%0d top=%0h expected len=0 top=0",
               frame_len, frame_data[FB*8-1 -: 64]);
    end
    checks++;
    if ({frame_valid, checksum_error, format_error, overflow_error, busy, rx_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: got fv/ce/fe/oe/busy/ready=%b expected 000001",
               {frame_valid, checksum_error, format_error, overflow_error, busy, rx_ready});
    end
    checks++;
    if (state_dbg !== SYNC) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", state_dbg, SYNC);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    logic [FB*8-1:0] exp_frame;
    exp_frame = '0;
    exp_frame[FB*8-1 -: 32] = 32'h383D4101;
    clear_counts();
    send_str("8=A|10=183|");
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0 || frame_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL good_check_cycle: got ready=%b fv=%b busy=%b expected ready=0 fv=0 busy=1",
               rx_ready, frame_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL good_pulse: got fv=%b ready=%b expected fv=1 ready=1", frame_valid, rx_ready);
    end
    checks++;
    if (frame_len !== LW'(4)) begin
      errors++;
      $display("FAIL good_len: got %0d expected 4", frame_len);
    end
    checks++;
    if (frame_data !== exp_frame) begin
      errors++;
      $display("FAIL good_data: got top=%0h low=%0h expected top=383d410100000000 low=0",
               frame_data[FB*8-1 -: 64], frame_data[FB*8-65:0] != '0);
    end
    @(negedge clk);
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL good_pulse_width: got fv=%b expected 0", frame_valid);
    end
    idle(2);
    check_counts("good", 1, 0, 0, 0);
  endtask

  task automatic test_checksum_error();
    clear_counts();
    send_str("8=A|10=184|");
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL cksum_ready_low: got %b expected 0", rx_ready);
    end
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || checksum_error !== 1'b1 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL cksum_pulse: got ready=%b ce=%b fv=%b expected ready=1 ce=1 fv=0",
               rx_ready, checksum_error, frame_valid);
    end
    idle(3);
    check_counts("cksum", 0, 1, 0, 0);
  endtask

  task automatic test_garbage_prefix();
    clear_counts();
    send_str("xx88=A|10=183|");
    idle(4);
    check_counts("garbage", 1, 0, 0, 0);
    checks++;
    if (last_len !== LW'(4) || last_top !== 32'h383D4101) begin
      errors++;
      $display("FAIL garbage_frame: got len=%0d top=%0h expected len=4 top=383d4101",
               last_len, last_top);
    end
  endtask

  task automatic test_overflow();
    clear_counts();
    send_str("8=");
    for (int i = 0; i < 260; i++) send_byte(8'h42);
    checks++;
    if (oe_cnt !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ovf_at_capacity: got oe_cnt=%0d busy=%b expected oe_cnt=0 busy=1", oe_cnt, busy);
    end
    send_byte(8'h42);
    checks++;
    if (overflow_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse: got oe=%b busy=%b expected oe=1 busy=0", overflow_error, busy);
    end
    send_str("8=A|10=183|");
    idle(4);
    check_counts("ovf", 1, 0, 0, 1);
    checks++;
    if (last_len !== LW'(4) || last_top !== 32'h383D4101) begin
      errors++;
      $display("FAIL ovf_recover: got len=%0d top=%0h expected len=4 top=383d4101", last_len, last_top);
    end
  endtask

  // 262-byte frame: "8=" + 259 x 'B' + SOH, sum = (0x75 + 259*0x42 + 1) mod 256 = 60.
  task automatic test_max_frame();
    clear_counts();
    send_str("8=");
    for (int i = 0; i < 259; i++) send_byte(8'h42);
    send_str("|10=060|");
    idle(3);
    check_counts("max", 1, 0, 0, 0);
    checks++;
    if (last_len !== LW'(262) || frame_data[15:0] !== 16'h4201) begin
      errors++;
      $display("FAIL max_frame: got len=%0d tail=%0h expected len=262 tail=4201",
               last_len, frame_data[15:0]);
    end
  endtask

  task automatic test_format_error();
    clear_counts();
    send_str("8=A|10=1x");
    checks++;
    if (format_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fmt_digit: got fe=%b busy=%b expected fe=1 busy=0", format_error, busy);
    end
    send_str("3|");
    send_str("8=A|10=183Z");
    checks++;
    if (format_error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fmt_soh: got fe=%b busy=%b expected fe=1 busy=0", format_error, busy);
    end
    idle(3);
    check_counts("fmt", 0, 0, 2, 0);
  endtask

  task automatic test_reset_mid_frame();
    logic [FB*8-1:0] zero_frame;
    zero_frame = '0;
    clear_counts();
    send_str("8=AB");
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || frame_len !== '0 || frame_data !== zero_frame || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b len=%0d top=%0h ready=%b expected busy=0 len=0 top=0 ready=1",
               busy, frame_len, frame_data[FB*8-1 -: 64], rx_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    send_str("8=A|10=183|");
    idle(4);
    check_counts("rst_mid", 1, 0, 0, 0);
    checks++;
    if (last_len !== LW'(4) || last_top !== 32'h383D4101) begin
      errors++;
      $display("FAIL rst_mid_frame: got len=%0d top=%0h expected len=4 top=383d4101", last_len, last_top);
    end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_str("8=A|10=183|8=B|10=184|");
    idle(4);
    check_counts("b2b", 2, 0, 0, 0);
    checks++;
    if (last_len !== LW'(4) || last_top !== 32'h383D4201) begin
      errors++;
      $display("FAIL b2b_second: got len=%0d top=%0h expected len=4 top=383d4201", last_len, last_top);
    end
  endtask

  initial begin
    clear_counts();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_checksum_error();
    test_garbage_prefix();
    test_overflow();
    test_max_frame();
    test_format_error();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
